// File: rtl/hc165_reader_pkg.sv
// Shared definitions for the 74HC165 chain reader: FSM state encoding and counter sizing.
package hc165_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE,
    ST_GAP
  } state_e;

  // Bits needed to count 0..n-1; never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/hc165_tick_gen.sv
// Half-period tick generator for the 74HC165 shift clock; restart re-aligns the phase.
module hc165_tick_gen
  import hc165_reader_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned CW = cnt_width(CLK_DIV);

  logic [CW-1:0] cnt;

  assign tick_c = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst || restart) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hc165_reader.sv
// Continuous 74HC165 chain scanner: PL/CP generation, serial capture, framed word output.
// Optional build macro HC165_DEBOUNCE_EN: publish only when two consecutive raw frames agree.
module hc165_reader
  import hc165_reader_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CLK_DIV  = 50,
  parameter int unsigned SCAN_GAP = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ser165,
  output logic             pl165,
  output logic             clk165,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy
);

  localparam int unsigned HALVES   = 2 * WIDTH;
  localparam int unsigned HC_W     = cnt_width(HALVES);
  localparam int unsigned GAP_W    = cnt_width(SCAN_GAP);
  localparam int unsigned GAP_LAST = (SCAN_GAP > 0) ? SCAN_GAP - 1 : 0;

  state_e           state, state_d;
  logic [HC_W-1:0]  hcnt, hcnt_d;
  logic [GAP_W-1:0] gcnt, gcnt_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic             clk165_d;
  logic             tick_c;
  logic             restart_c;
  logic             done_entry_c;
  logic             match_c;

  hc165_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart_c),
    .tick_c  (tick_c)
  );

  // Divider phase restarts on every LOAD entry so each frame has identical timing.
  assign restart_c    = (state_d == ST_LOAD) && (state != ST_LOAD);
  assign done_entry_c = (state_d == ST_DONE);

  always_comb begin
    state_d  = state;
    hcnt_d   = hcnt;
    gcnt_d   = gcnt;
    shreg_d  = shreg;
    clk165_d = clk165;
    unique case (state)
      ST_IDLE: begin
        hcnt_d = '0;
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (tick_c) begin
          if (hcnt == HC_W'(1)) begin
            state_d = ST_SHIFT;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt + HC_W'(1);
          end
        end
      end
      ST_SHIFT: begin
        // Even halves are clk165 low; sample just before the rising edge.
        if (tick_c) begin
          if (!hcnt[0]) begin
            shreg_d  = {shreg[WIDTH-2:0], ser165};
            clk165_d = 1'b1;
          end else begin
            clk165_d = 1'b0;
          end
          if (hcnt == HC_W'(HALVES - 1)) begin
            state_d = ST_DONE;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt + HC_W'(1);
          end
        end
      end
      ST_DONE: begin
        hcnt_d = '0;
        gcnt_d = '0;
        if (SCAN_GAP == 0) state_d = en ? ST_LOAD : ST_IDLE;
        else               state_d = ST_GAP;
      end
      ST_GAP: begin
        hcnt_d = '0;
        if (gcnt == GAP_W'(GAP_LAST)) begin
          state_d = en ? ST_LOAD : ST_IDLE;
          gcnt_d  = '0;
        end else begin
          gcnt_d = gcnt + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef HC165_DEBOUNCE_EN
  logic [WIDTH-1:0] prev_frame;
  logic             prev_ok;

  assign match_c = prev_ok && (shreg_d == prev_frame);

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_frame <= '0;
      prev_ok    <= 1'b0;
    end else if (done_entry_c) begin
      prev_frame <= shreg_d;
      prev_ok    <= 1'b1;
    end
  end
`else
  assign match_c = 1'b1;
`endif

  // State register plus outputs registered from the next state (glitch-free pins).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      hcnt       <= '0;
      gcnt       <= '0;
      shreg      <= '0;
      pl165      <= 1'b1;
      clk165     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      hcnt       <= hcnt_d;
      gcnt       <= gcnt_d;
      shreg      <= shreg_d;
      pl165      <= (state_d != ST_LOAD);
      clk165     <= clk165_d;
      busy       <= (state_d == ST_LOAD) || (state_d == ST_SHIFT);
      data_valid <= done_entry_c && match_c;
      if (done_entry_c && match_c) data_out <= shreg_d;
    end
  end

endmodule

// File: tb/tb_hc165_reader.sv
// Bench for hc165_reader: behavioural 74HC165 chains, frame-level reference model, random pins.
module tb_hc165_reader;

  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned SCAN_GAP  = 4;
  localparam int          FRAME_LEN = (8 + 1) * 2 * CLK_DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8 = 1'b0, en8 = 1'b0, ser8, pl8, ck8, dv8, busy8;
  logic [7:0]  do8;
  logic        rst16 = 1'b0, en16 = 1'b0, ser16, pl16, ck16, dv16, busy16;
  logic [15:0] do16;

  hc165_reader #(.WIDTH(8), .CLK_DIV(CLK_DIV), .SCAN_GAP(SCAN_GAP)) u_dut8 (
    .clk(clk), .rst(rst8), .en(en8), .ser165(ser8), .pl165(pl8), .clk165(ck8),
    .data_out(do8), .data_valid(dv8), .busy(busy8));

  hc165_reader #(.WIDTH(16), .CLK_DIV(CLK_DIV), .SCAN_GAP(SCAN_GAP)) u_dut16 (
    .clk(clk), .rst(rst16), .en(en16), .ser165(ser16), .pl165(pl16), .clk165(ck16),
    .data_out(do16), .data_valid(dv16), .busy(busy16));

  // 74HC165 chains: PL low loads the pins, CP rising shifts toward Q7, DS tied low.
  logic [7:0]  pins8 = 8'h00, chain8 = 8'h00;
  logic [15:0] pins16 = 16'h0000, chain16 = 16'h0000;
  int          rises8 = 0;

  always @(negedge pl8 or posedge ck8)
    if (!pl8) chain8 <= pins8;
    else      chain8 <= {chain8[6:0], 1'b0};
  assign ser8 = chain8[7];

  always @(negedge pl16 or posedge ck16)
    if (!pl16) chain16 <= pins16;
    else       chain16 <= {chain16[14:0], 1'b0};
  assign ser16 = chain16[15];

  always @(posedge ck8) rises8++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame-level reference: what a completed scan of raw pins should publish.
  bit         have_prev8 = 1'b0;
  logic [7:0] prev_raw8  = 8'h00;
  logic [7:0] exp_do8    = 8'h00;

  function automatic bit model_frame8(input logic [7:0] raw);
    bit pub;
`ifdef HC165_DEBOUNCE_EN
    pub = have_prev8 && (raw == prev_raw8);
`else
    pub = 1'b1;
`endif
    have_prev8 = 1'b1;
    prev_raw8  = raw;
    if (pub) exp_do8 = raw;
    return pub;
  endfunction

  task automatic model_reset8();
    have_prev8 = 1'b0;
    prev_raw8  = 8'h00;
    exp_do8    = 8'h00;
  endtask

  // Observe one 8-bit frame from LOAD entry; optionally drop en after drop_at rising edges.
  task automatic run_frame8(input string tag, input int drop_at);
    int         waited, pl_low, lat, nstrobe, overlap, r0;
    logic [7:0] raw;
    bit         exp_pub;
    waited = 0; pl_low = 0; lat = -1; nstrobe = 0; overlap = 0;
    while (pl8 !== 1'b0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " load_seen"}, 64'(pl8 === 1'b0), 64'd1);
    raw = pins8;
    r0  = rises8;
    exp_pub = model_frame8(raw);
    for (int t = 0; t < FRAME_LEN + 2; t++) begin
      if (pl8 === 1'b0) pl_low++;
      if (pl8 === 1'b0 && ck8 === 1'b1) overlap++;
      if (dv8 === 1'b1) begin
        nstrobe++;
        if (lat < 0) lat = t;
      end
      if (drop_at >= 0 && (rises8 - r0) >= drop_at) en8 = 1'b0;
      @(negedge clk);
    end
    check({tag, " pl_low"},  64'(pl_low), 64'(2 * CLK_DIV));
    check({tag, " rises"},   64'(rises8 - r0), 64'd8);
    check({tag, " overlap"}, 64'(overlap), 64'd0);
    check({tag, " strobes"}, 64'(nstrobe), 64'(exp_pub));
    if (exp_pub) check({tag, " latency"}, 64'(lat), 64'(FRAME_LEN));
    check({tag, " data"}, 64'(do8), 64'(exp_do8));
  endtask

  task automatic wait_strobe16(input string tag, output logic [15:0] v);
    int waited;
    waited = 0;
    @(negedge clk);
    while (dv16 !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " strobe_seen"}, 64'(dv16 === 1'b1), 64'd1);
    check({tag, " busy_in_done"}, 64'(busy16), 64'd0);
    v = do16;
  endtask

  initial begin
    logic [15:0] v16;
    int          cnt_pl, cnt_ck, cnt_dv, cnt_busy, waited, r0;

    // Reset held with en high.
    en8 = 1'b1;
    repeat (10) @(negedge clk);
    check("rst pl165",  64'(pl8),   64'd1);
    check("rst clk165", 64'(ck8),   64'd0);
    check("rst data",   64'(do8),   64'd0);
    check("rst valid",  64'(dv8),   64'd0);
    check("rst busy",   64'(busy8), 64'd0);

    // Single read of 8'hA5, then a repeat so a debounced build also publishes.
    pins8 = 8'hA5;
    rst8  = 1'b1;
    run_frame8("a5_first", -1);
    run_frame8("a5_second", -1);

    // Random pin patterns; sometimes repeated to exercise debouncing.
    for (int f = 0; f < 10; f++) begin
      if ($urandom_range(0, 2) != 0) pins8 = 8'($urandom);
      run_frame8($sformatf("rand%0d", f), -1);
    end

    // en dropped after bit 3: the frame still completes, then the scanner stops.
    run_frame8("endrop", 4);
    cnt_pl = 0; cnt_ck = 0; cnt_dv = 0; cnt_busy = 0;
    repeat (200) begin
      @(negedge clk);
      if (pl8 !== 1'b1)   cnt_pl++;
      if (ck8 !== 1'b0)   cnt_ck++;
      if (dv8 !== 1'b0)   cnt_dv++;
      if (busy8 !== 1'b0) cnt_busy++;
    end
    check("idle pl165_active", 64'(cnt_pl),   64'd0);
    check("idle clk165_high",  64'(cnt_ck),   64'd0);
    check("idle strobes",      64'(cnt_dv),   64'd0);
    check("idle busy",         64'(cnt_busy), 64'd0);
    check("idle data_hold",    64'(do8),      64'(exp_do8));

    // Reset in the middle of SHIFT.
    pins8 = 8'h5A;
    en8   = 1'b1;
    waited = 0;
    while (pl8 !== 1'b0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    r0 = rises8;
    while ((rises8 - r0) < 3 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check("midrst reached_shift", 64'(rises8 - r0), 64'd3);
    rst8 = 1'b0;
    @(negedge clk);
    check("midrst pl165",  64'(pl8),   64'd1);
    check("midrst clk165", 64'(ck8),   64'd0);
    check("midrst data",   64'(do8),   64'd0);
    check("midrst valid",  64'(dv8),   64'd0);
    check("midrst busy",   64'(busy8), 64'd0);
    model_reset8();
    rst8 = 1'b1;
    run_frame8("postrst1", -1);
    run_frame8("postrst2", -1);

    // Alternating pins, then a steady pattern.
    for (int f = 0; f < 4; f++) begin
      pins8 = f[0] ? 8'hF0 : 8'h0F;
      run_frame8($sformatf("alt%0d", f), -1);
    end
    pins8 = 8'h3C;
    for (int f = 0; f < 3; f++) run_frame8($sformatf("steady%0d", f), -1);
    en8 = 1'b0;

    // 16-bit chain: chip nearest the FPGA lands in the upper byte.
    pins16 = {8'h12, 8'h34};
    rst16  = 1'b1;
    en16   = 1'b1;
    wait_strobe16("chain16 first", v16);
    check("chain16 first data", 64'(v16), 64'h1234);
    pins16 = 16'hFFFF;
    wait_strobe16("chain16 ffff", v16);
    check("chain16 ffff data", 64'(v16), 64'hFFFF);
    en16 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
